// File: rtl/mispredict_recovery_ctrl_if.sv
// Bundle between the retire/fetch/store-queue side and the mispredict
// recovery sequencer. master = environment, slave = the sequencer.
interface mispredict_recovery_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int ARCH_REGS = 32,
  parameter int CNT_WIDTH = 16
);
  localparam int BASE_W = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;

  logic                  mispredict;
  logic [XLEN-1:0]       mispredict_target_pc;
  logic                  sq_empty;
  logic                  fetch_ready;

  logic                  flush;
  logic                  restore_en;
  logic [BASE_W-1:0]     restore_base;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  stall_dispatch;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  recover_count;

  modport master (
    output mispredict, mispredict_target_pc, sq_empty, fetch_ready,
    input  flush, restore_en, restore_base, redirect_valid, redirect_pc,
           stall_dispatch, busy, recover_count
  );

  modport slave (
    input  mispredict, mispredict_target_pc, sq_empty, fetch_ready,
    output flush, restore_en, restore_base, redirect_valid, redirect_pc,
           stall_dispatch, busy, recover_count
  );
endinterface

// File: rtl/mispredict_recovery_ctrl.sv
// Mispredict recovery sequencer: latch corrected PC, flush speculative
// state for one cycle, restore the speculative map table in chunks,
// wait for the store queue to drain, then redirect fetch via valid/ready.
// Every output is decoded from registered state only.
module mispredict_recovery_ctrl #(
  parameter int XLEN              = 32,
  parameter int ARCH_REGS         = 32,
  parameter int RESTORE_PER_CYCLE = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  mispredict_recovery_ctrl_if.slave   bus
);
  localparam int K       = ARCH_REGS / RESTORE_PER_CYCLE;
  localparam int BASE_W  = (ARCH_REGS > 1) ? $clog2(ARCH_REGS) : 1;
  localparam int CHUNK_W = (K > 1) ? $clog2(K) : 1;
  localparam int SHIFT   = $clog2(RESTORE_PER_CYCLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RESTORE,
    S_DRAIN,
    S_REDIRECT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [XLEN-1:0]      r_pc;
  logic [CHUNK_W-1:0]   r_chunk;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_accept;
  logic                 w_last_chunk;

  assign w_accept     = (r_state == S_IDLE) && bus.mispredict;
  assign w_last_chunk = (r_chunk == CHUNK_W'(K - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing; inputs only matter in the state that owns them
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.mispredict)  w_next = S_FLUSH;
      S_FLUSH:                         w_next = S_RESTORE;
      S_RESTORE:  if (w_last_chunk)    w_next = S_DRAIN;
      S_DRAIN:    if (bus.sq_empty)    w_next = S_REDIRECT;
      S_REDIRECT: if (bus.fetch_ready) w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  // Latched target PC, chunk counter and saturating recovery counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= '0;
      r_chunk <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_pc <= bus.mispredict_target_pc;
        if (r_count != '1) r_count <= r_count + 1'b1;
      end
      // Counter is held at zero outside RESTORE so each restore starts at chunk 0
      if (r_state == S_RESTORE) r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
      else                      r_chunk <= '0;
    end
  end

  // Output decode from registered state
  always_comb begin
    bus.flush          = 1'b0;
    bus.restore_en     = 1'b0;
    bus.restore_base   = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = r_pc;
    bus.busy           = (r_state != S_IDLE);
    bus.stall_dispatch = (r_state != S_IDLE);
    bus.recover_count  = r_count;
    case (r_state)
      S_FLUSH:    bus.flush = 1'b1;
      S_RESTORE: begin
        bus.restore_en   = 1'b1;
        bus.restore_base = BASE_W'(r_chunk) << SHIFT;
      end
      S_REDIRECT: bus.redirect_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
module tb_mispredict_recovery_ctrl;
  localparam int XLEN    = 32;
  localparam int ARCH    = 32;
  localparam int RPC     = 8;
  localparam int K       = ARCH / RPC;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mispredict_recovery_ctrl_if #(.XLEN(XLEN), .ARCH_REGS(ARCH), .CNT_WIDTH(CNT_W)) u_if ();
  mispredict_recovery_ctrl_if #(.XLEN(XLEN), .ARCH_REGS(ARCH), .CNT_WIDTH(2))     u_if2 ();

  mispredict_recovery_ctrl #(
    .XLEN(XLEN), .ARCH_REGS(ARCH), .RESTORE_PER_CYCLE(RPC), .CNT_WIDTH(CNT_W)
  ) u_dut (.clock(clock), .reset(reset), .bus(u_if));

  mispredict_recovery_ctrl #(
    .XLEN(XLEN), .ARCH_REGS(ARCH), .RESTORE_PER_CYCLE(RPC), .CNT_WIDTH(2)
  ) u_dut_sat (.clock(clock), .reset(reset), .bus(u_if2));

  // Reference model: a recovery is "active" from acceptance; age counts cycles
  // since acceptance until the drain completes, then a redirect phase follows.
  bit              m_active = 1'b0;
  bit              m_redir  = 1'b0;
  int              m_age    = 0;
  logic [XLEN-1:0] m_pc     = '0;
  int              m_cnt    = 0;

  task automatic model_tick();
    if (reset) begin
      m_active = 1'b0; m_redir = 1'b0; m_age = 0; m_pc = '0; m_cnt = 0;
    end else if (!m_active) begin
      if (u_if.mispredict) begin
        m_active = 1'b1; m_redir = 1'b0; m_age = 1;
        m_pc = u_if.mispredict_target_pc;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else if (m_redir) begin
      if (u_if.fetch_ready) begin m_active = 1'b0; m_redir = 1'b0; end
    end else begin
      if (m_age >= K + 2 && u_if.sq_empty) m_redir = 1'b1;
      m_age++;
    end
  endtask

  function automatic logic [57:0] exp_vec();
    logic       e_f, e_r, e_v;
    logic [4:0] e_b;
    e_f = m_active && !m_redir && (m_age == 1);
    e_r = m_active && !m_redir && (m_age >= 2) && (m_age <= K + 1);
    e_b = e_r ? 5'((m_age - 2) * RPC) : 5'd0;
    e_v = m_active && m_redir;
    return {e_f, e_r, e_b, e_v, m_pc, m_active, m_active, 16'(m_cnt)};
  endfunction

  function automatic logic [57:0] obs_vec();
    return {u_if.flush, u_if.restore_en, u_if.restore_base, u_if.redirect_valid,
            u_if.redirect_pc, u_if.stall_dispatch, u_if.busy, u_if.recover_count};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_vec() !== 58'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs_vec(), 58'd0);
      end
    end
  endtask

  task automatic test_basic();
    int         base_cnt;
    logic [8:0] d_obs, d_exp;
    base_cnt = m_cnt;
    u_if.sq_empty = 1'b1; u_if.fetch_ready = 1'b1;
    u_if.mispredict = 1'b1; u_if.mispredict_target_pc = 32'h0000_1040;
    tick();
    u_if.mispredict = 1'b0; u_if.mispredict_target_pc = 32'hDEAD_BEEF;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      d_obs = {u_if.flush, u_if.restore_en, u_if.restore_base, u_if.redirect_valid, u_if.busy};
      d_exp = {k == 1, (k >= 2 && k <= 5), 5'((k >= 2 && k <= 5) ? (k - 2) * 8 : 0), k == 7, k <= 7};
      checks++;
      if (d_obs !== d_exp) begin
        errors++;
        $display("FAIL basic_seq k=%0d: got %b expected %b", k, d_obs, d_exp);
      end
      if (k == 7) begin
        checks++;
        if (u_if.redirect_pc !== 32'h1040) begin
          errors++;
          $display("FAIL basic_pc: got %h expected %h", u_if.redirect_pc, 32'h1040);
        end
      end
      tick();
    end
    checks++;
    if (u_if.recover_count !== 16'(base_cnt + 1)) begin
      errors++;
      $display("FAIL basic_count: got %0d expected %0d", u_if.recover_count, base_cnt + 1);
    end
  endtask

  task automatic test_stall();
    logic [3:0] d_obs, d_exp;
    u_if.sq_empty = 1'b0; u_if.fetch_ready = 1'b0;
    u_if.mispredict = 1'b1; u_if.mispredict_target_pc = 32'h0000_1040;
    tick();
    u_if.mispredict = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      if (k >= 6) begin
        d_obs = {u_if.busy, u_if.flush | u_if.restore_en, u_if.redirect_valid,
                 u_if.redirect_pc == 32'h1040};
        d_exp = {k <= 14, 1'b0, (k >= 11 && k <= 14), 1'b1};
        checks++;
        if (d_obs !== d_exp) begin
          errors++;
          $display("FAIL stall_seq k=%0d: got %b expected %b", k, d_obs, d_exp);
        end
      end
      u_if.sq_empty    = (k >= 10);
      u_if.fetch_ready = (k >= 14);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int base_cnt;
    base_cnt = m_cnt;
    u_if.sq_empty = 1'b1; u_if.fetch_ready = 1'b1;
    u_if.mispredict = 1'b1; u_if.mispredict_target_pc = 32'h0000_1040;
    tick();
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      if (k == 7) begin
        checks++;
        if ({u_if.redirect_valid, u_if.redirect_pc, u_if.recover_count} !==
            {1'b1, 32'h1040, 16'(base_cnt + 1)}) begin
          errors++;
          $display("FAIL ignore_mid: got v=%b pc=%h cnt=%0d expected v=1 pc=1040 cnt=%0d",
                   u_if.redirect_valid, u_if.redirect_pc, u_if.recover_count, base_cnt + 1);
        end
      end
      u_if.mispredict = (k == 3 || k == 8);
      u_if.mispredict_target_pc = (k == 3) ? 32'h2000 : (k == 8) ? 32'h3000 : 32'h0;
      tick();
    end
    u_if.mispredict = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b2_model j=%0d: got %h expected %h", j, obs_vec(), exp_vec());
      end
      if (j == 7) begin
        checks++;
        if ({u_if.redirect_valid, u_if.redirect_pc, u_if.recover_count} !==
            {1'b1, 32'h3000, 16'(base_cnt + 2)}) begin
          errors++;
          $display("FAIL b2b_second: got v=%b pc=%h cnt=%0d expected v=1 pc=3000 cnt=%0d",
                   u_if.redirect_valid, u_if.redirect_pc, u_if.recover_count, base_cnt + 2);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    u_if.sq_empty = 1'b1; u_if.fetch_ready = 1'b1;
    u_if.mispredict = 1'b1; u_if.mispredict_target_pc = 32'h0000_4444;
    tick();
    u_if.mispredict = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    checks++;
    if ({u_if.restore_en, u_if.restore_base} !== {1'b1, 5'd16}) begin
      errors++;
      $display("FAIL rstmid_pre: got en=%b base=%0d expected en=1 base=16",
               u_if.restore_en, u_if.restore_base);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs_vec() !== 58'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got %h expected %h", obs_vec(), 58'd0);
    end
    u_if.mispredict = 1'b1; u_if.mispredict_target_pc = 32'h0000_5000;
    tick();
    u_if.mispredict = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      if (k == 2) begin
        checks++;
        if ({u_if.restore_en, u_if.restore_base} !== {1'b1, 5'd0}) begin
          errors++;
          $display("FAIL rstmid_restart: got en=%b base=%0d expected en=1 base=0",
                   u_if.restore_en, u_if.restore_base);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      u_if.mispredict           = ($urandom_range(0, 3) == 0);
      u_if.mispredict_target_pc = $urandom;
      u_if.sq_empty             = ($urandom_range(0, 1) == 1);
      u_if.fetch_ready          = ($urandom_range(0, 2) == 0);
      reset                     = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    reset = 1'b0;
    u_if.mispredict = 1'b0;
  endtask

  task automatic test_saturate();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      u_if2.mispredict = 1'b1; u_if2.mispredict_target_pc = 32'(i);
      tick();
      u_if2.mispredict = 1'b0;
      n = 0;
      while (u_if2.busy && n < 20) begin tick(); n++; end
      checks++;
      if ({u_if2.busy, u_if2.recover_count} !== {1'b0, 2'((i > 3) ? 3 : i)}) begin
        errors++;
        $display("FAIL saturate run %0d: got busy=%b cnt=%0d expected busy=0 cnt=%0d",
                 i, u_if2.busy, u_if2.recover_count, (i > 3) ? 3 : i);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    u_if.mispredict = 1'b0;  u_if.mispredict_target_pc = '0;
    u_if.sq_empty = 1'b1;    u_if.fetch_ready = 1'b1;
    u_if2.mispredict = 1'b0; u_if2.mispredict_target_pc = '0;
    u_if2.sq_empty = 1'b1;   u_if2.fetch_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
